ram_bank_array: RTL and testbench

Parametrised data-RAM subsystem for the 4-bit CPU bus. It replaces individual hand-instanced RAM chips with one block serving `BANKS` command lines of `CHIPS` chips each. Each chip holds 4 registers of 16 main characters plus 4 status characters, and has a 4-bit output port. The block tracks the 8-phase bus cycle from `sync` itself, decodes SRC addressing and RAM I/O opcodes, and drives read data onto the bus.

---
 rtl/ram_bank_array.sv | 188 ++++++++++++++++++
 tb/tb_ram_bank_array.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bank_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_bank_array
// Description : Data-RAM subsystem for the 4-bit CPU bus. Serves BANKS
//               command lines of CHIPS chips each (4 registers x 16 main
//               + 4 status nibbles per chip, plus a 4-bit output port).
//               Tracks the 8-phase bus cycle from sync, decodes SRC and
//               RAM I/O opcodes, and drives read data onto the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bank_array #(
    parameter int BANKS = 4,
    parameter int CHIPS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sync,
    input  logic [BANKS-1:0]          cmd_n,
    input  logic [3:0]                data_i,
    output logic [3:0]                data_o,
    output logic                      data_oe,
    output logic [BANKS*CHIPS*4-1:0]  port_out
);

    localparam int DEPTH = BANKS * CHIPS * 4 * 20;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_A1   = 4'd1;
    localparam logic [3:0] S_A2   = 4'd2;
    localparam logic [3:0] S_A3   = 4'd3;
    localparam logic [3:0] S_M1   = 4'd4;
    localparam logic [3:0] S_M2   = 4'd5;
    localparam logic [3:0] S_X1   = 4'd6;
    localparam logic [3:0] S_X2   = 4'd7;
    localparam logic [3:0] S_X3   = 4'd8;

    logic [3:0]    r_phase;
    logic          r_src_seen;
    logic          r_src_valid;
    logic          r_io_pend;
    logic [1:0]    r_sel_bank;
    logic [1:0]    r_sel_chip;
    logic [1:0]    r_sel_reg;
    logic [3:0]    r_sel_char;
    logic [3:0]    r_opa;
    logic [3:0]    r_mem [DEPTH];

    logic          w_any_cmd;
    logic [1:0]    w_low_bank;
    logic          w_bank_cmd;
    logic          w_chip_ok;
    logic          w_src_x2;
    logic [4:0]    w_char_off;
    logic [AW-1:0] w_addr;
    logic [3:0]    w_rd_data;
    logic          w_is_read;
    logic          w_is_mwr;
    logic          w_is_wmp;
    logic          w_exec;
    logic          w_mem_we;
    logic          w_port_we;
    logic          w_rd_load;

    // Command-line decode: lowest active bank for SRC, selected bank's line for I/O
    always_comb begin
        w_any_cmd  = ~&cmd_n;
        w_low_bank = 2'd0;
        w_bank_cmd = 1'b0;
        for (int b = BANKS - 1; b >= 0; b--) begin
            if (!cmd_n[b]) begin
                w_low_bank = 2'(b);
            end
        end
        for (int b = 0; b < BANKS; b++) begin
            if (r_sel_bank == 2'(b)) begin
                w_bank_cmd = !cmd_n[b];
            end
        end
    end

    // Address generation and opcode classification for the pending I/O op
    always_comb begin
        w_chip_ok  = int'(r_sel_chip) < CHIPS;
        // Status ops (4-7, C-F) all have opa[2] set; main-memory ops do not
        w_char_off = r_opa[2] ? {3'b100, r_opa[1:0]} : {1'b0, r_sel_char};
        w_addr     = ((AW'(r_sel_bank) * AW'(CHIPS) + AW'(r_sel_chip)) * AW'(4)
                      + AW'(r_sel_reg)) * AW'(20) + AW'(w_char_off);
        w_rd_data  = r_mem[w_addr];
        w_is_read  = r_opa[3] && (r_opa != 4'hA);
        w_is_mwr   = (r_opa == 4'h0) || (r_opa[3:2] == 2'b01);
        w_is_wmp   = (r_opa == 4'h1);
        // A sync arriving mid-cycle aborts whatever the cycle was doing
        w_exec     = r_io_pend && w_chip_ok && !sync;
        w_mem_we   = (r_phase == S_X2) && w_exec && w_is_mwr;
        w_port_we  = (r_phase == S_X2) && w_exec && w_is_wmp;
        w_rd_load  = (r_phase == S_X1) && w_exec && w_is_read;
        w_src_x2   = (r_phase == S_X2) && !sync && w_any_cmd;
    end

    // Bus phase counter: sync restarts at A1, X3 free-runs to A1, IDLE waits
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_phase <= S_IDLE;
        end else if (sync) begin
            r_phase <= S_A1;
        end else begin
            case (r_phase)
                S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2: r_phase <= r_phase + 4'd1;
                S_X3:    r_phase <= S_A1;
                default: r_phase <= S_IDLE;
            endcase
        end
    end

    // SRC capture: bank/chip/register at X2, character at the following X3
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_src_seen  <= 1'b0;
            r_src_valid <= 1'b0;
            r_sel_bank  <= 2'd0;
            r_sel_chip  <= 2'd0;
            r_sel_reg   <= 2'd0;
            r_sel_char  <= 4'd0;
        end else begin
            r_src_seen <= w_src_x2;
            if (w_src_x2) begin
                r_sel_bank <= w_low_bank;
                r_sel_chip <= data_i[3:2];
                r_sel_reg  <= data_i[1:0];
            end
            if ((r_phase == S_X3) && r_src_seen) begin
                r_sel_char  <= data_i;
                r_src_valid <= 1'b1;
            end
        end
    end

    // I/O opcode capture at M2; pending flag lives until the end of X2
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_opa     <= 4'd0;
            r_io_pend <= 1'b0;
        end else if (sync || (r_phase == S_X2)) begin
            r_io_pend <= 1'b0;
        end else if ((r_phase == S_M2) && r_src_valid && w_bank_cmd) begin
            r_opa     <= data_i;
            r_io_pend <= 1'b1;
        end
    end

    // Read data register: loaded entering X2, output enable held only for X2
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_o  <= 4'd0;
            data_oe <= 1'b0;
        end else if (w_rd_load) begin
            data_o  <= w_rd_data;
            data_oe <= 1'b1;
        end else if (sync || (r_phase == S_X2)) begin
            data_oe <= 1'b0;
        end
    end

    // Chip output ports, written by WMP at the end of X2
    always_ff @(posedge clock) begin
        if (!reset) begin
            port_out <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                for (int c = 0; c < CHIPS; c++) begin
                    if (w_port_we && (r_sel_bank == 2'(b)) && (r_sel_chip == 2'(c))) begin
                        port_out[4*(b*CHIPS+c) +: 4] <= data_i;
                    end
                end
            end
        end
    end

    // Nibble storage, not reset; writes are suppressed while reset is held
    always_ff @(posedge clock) begin
        if (reset && w_mem_we) begin
            r_mem[w_addr] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_bank_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_bank_array
// Description : Self-checking bench for ram_bank_array. Two instances share
//               the bus: a fully populated 4x4 array and a 4x2 array whose
//               chips 2-3 are absent. Bus cycles come from a vector table;
//               abort, reset and free-run cases are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bank_array;

    localparam logic [3:0] PH_IDLE = 4'd0;
    localparam logic [3:0] PH_A1   = 4'd1;
    localparam logic [3:0] PH_X1   = 4'd6;
    localparam logic [3:0] PH_X2   = 4'd7;
    localparam logic [3:0] PH_X3   = 4'd8;
    localparam logic [7:0] OE_X2   = 8'h40;

    logic        clock = 1'b0;
    logic        reset;
    logic        sync;
    logic [3:0]  cmd_n;
    logic [3:0]  data_i;
    logic [3:0]  data_o;
    logic        data_oe;
    logic [63:0] port_out;
    logic [3:0]  data_o2;
    logic        data_oe2;
    logic [31:0] port_out2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [3:0] cm_m2;
        logic [3:0] cm_x2;
        logic [3:0] d_m2;
        logic [3:0] d_x2;
        logic [3:0] d_x3;
        logic [7:0] oe1;
        logic [3:0] do1;
        logic [63:0] pt1;
        logic [7:0] oe2;
        logic [3:0] do2;
        logic [31:0] pt2;
    } vec_t;

    vec_t tbl [$];

    always #5 clock = ~clock;

    ram_bank_array #(.BANKS(4), .CHIPS(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .sync     (sync),
        .cmd_n    (cmd_n),
        .data_i   (data_i),
        .data_o   (data_o),
        .data_oe  (data_oe),
        .port_out (port_out)
    );

    ram_bank_array #(.BANKS(4), .CHIPS(2)) dut2 (
        .clock    (clock),
        .reset    (reset),
        .sync     (sync),
        .cmd_n    (cmd_n),
        .data_i   (data_i),
        .data_o   (data_o2),
        .data_oe  (data_oe2),
        .port_out (port_out2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input string n, input logic [3:0] cm_m2, input logic [3:0] cm_x2,
                       input logic [3:0] d_m2, input logic [3:0] d_x2, input logic [3:0] d_x3,
                       input logic [7:0] oe1, input logic [3:0] do1, input logic [63:0] pt1,
                       input logic [7:0] oe2, input logic [3:0] do2, input logic [31:0] pt2);
        vec_t v;
        v.name = n; v.cm_m2 = cm_m2; v.cm_x2 = cm_x2;
        v.d_m2 = d_m2; v.d_x2 = d_x2; v.d_x3 = d_x3;
        v.oe1 = oe1; v.do1 = do1; v.pt1 = pt1;
        v.oe2 = oe2; v.do2 = do2; v.pt2 = pt2;
        tbl.push_back(v);
    endtask

    // One full bus cycle starting in A1; sync is raised during X3
    task automatic run_bus(input logic [3:0] cm_m2, input logic [3:0] cm_x2,
                           input logic [3:0] d_m2, input logic [3:0] d_x2, input logic [3:0] d_x3,
                           output logic [7:0] oe1, output logic [7:0] oe2,
                           output logic [3:0] do1, output logic [3:0] do2);
        oe1 = 8'h0; oe2 = 8'h0; do1 = 4'h0; do2 = 4'h0;
        for (int p = 0; p < 8; p++) begin
            sync   = (p == 7);
            cmd_n  = (p == 4) ? cm_m2 : (p == 6) ? cm_x2 : 4'hF;
            data_i = (p == 4) ? d_m2 : (p == 6) ? d_x2 : (p == 7) ? d_x3 : 4'h0;
            oe1[p] = data_oe;
            oe2[p] = data_oe2;
            if (p == 6) begin
                do1 = data_o;
                do2 = data_o2;
            end
            tick();
        end
        sync = 1'b0; cmd_n = 4'hF; data_i = 4'h0;
    endtask

    // Drive phases A1..(last-1) of an RDM so the next tick ends phase 'last'
    task automatic rdm_prefix(input int upto);
        for (int p = 0; p < upto; p++) begin
            sync   = 1'b0;
            cmd_n  = (p == 4) ? 4'hD : 4'hF;
            data_i = (p == 4) ? 4'h9 : 4'h0;
            tick();
        end
        cmd_n = 4'hF; data_i = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] o1, o2;
        logic [3:0] r1, r2;
        logic       any_bad;

        //  name            cm_m2 cm_x2 d_m2 d_x2 d_x3  oe1    do1  pt1            oe2    do2  pt2
        add("idle",         4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("src_b1c1r2",   4'hF, 4'hD, 4'h0, 4'h6, 4'hA, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("wrm_5",        4'hD, 4'hF, 4'h0, 4'h5, 4'h0, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("rdm",          4'hD, 4'hF, 4'h9, 4'h0, 4'h0, OE_X2, 4'h5, 64'h0,        OE_X2, 4'h5, 32'h0);
        add("rdm_wrongbank",4'hB, 4'hF, 4'h9, 4'h0, 4'h0, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("wr2_c",        4'hD, 4'hF, 4'h6, 4'hC, 4'h0, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("rd2",          4'hD, 4'hF, 4'hE, 4'h0, 4'h0, OE_X2, 4'hC, 64'h0,        OE_X2, 4'hC, 32'h0);
        add("wr0_3",        4'hD, 4'hF, 4'h4, 4'h3, 4'h0, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("rd0",          4'hD, 4'hF, 4'hC, 4'h0, 4'h0, OE_X2, 4'h3, 64'h0,        OE_X2, 4'h3, 32'h0);
        add("rd2_again",    4'hD, 4'hF, 4'hE, 4'h0, 4'h0, OE_X2, 4'hC, 64'h0,        OE_X2, 4'hC, 32'h0);
        add("rdm_main_kept",4'hD, 4'hF, 4'h9, 4'h0, 4'h0, OE_X2, 4'h5, 64'h0,        OE_X2, 4'h5, 32'h0);
        add("opc_a",        4'hD, 4'hF, 4'hA, 4'h0, 4'h0, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("sbm",          4'hD, 4'hF, 4'h8, 4'h0, 4'h0, OE_X2, 4'h5, 64'h0,        OE_X2, 4'h5, 32'h0);
        add("adm",          4'hD, 4'hF, 4'hB, 4'h0, 4'h0, OE_X2, 4'h5, 64'h0,        OE_X2, 4'h5, 32'h0);
        add("src_multi",    4'hF, 4'h5, 4'h0, 4'h6, 4'hA, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("rdm_multi",    4'hD, 4'hF, 4'h9, 4'h0, 4'h0, OE_X2, 4'h5, 64'h0,        OE_X2, 4'h5, 32'h0);
        add("src_b0c3r0",   4'hF, 4'hE, 4'h0, 4'hC, 4'h0, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("wrm_c3",       4'hE, 4'hF, 4'h0, 4'h7, 4'h0, 8'h00, 4'h0, 64'h0,        8'h00, 4'h0, 32'h0);
        add("rdm_c3",       4'hE, 4'hF, 4'h9, 4'h0, 4'h0, OE_X2, 4'h7, 64'h0,        8'h00, 4'h0, 32'h0);
        add("wmp_c3",       4'hE, 4'hF, 4'h1, 4'h9, 4'h0, 8'h00, 4'h0, 64'h9000,     8'h00, 4'h0, 32'h0);
        add("opc_2",        4'hE, 4'hF, 4'h2, 4'hF, 4'h0, 8'h00, 4'h0, 64'h9000,     8'h00, 4'h0, 32'h0);
        add("src_b1c1_b",   4'hF, 4'hD, 4'h0, 4'h6, 4'hA, 8'h00, 4'h0, 64'h9000,     8'h00, 4'h0, 32'h0);
        add("wmp_b1c1",     4'hD, 4'hF, 4'h1, 4'h3, 4'h0, 8'h00, 4'h0, 64'h309000,   8'h00, 4'h0, 32'h3000);

        // Reset state and the first sync
        reset = 1'b0; sync = 1'b0; cmd_n = 4'hF; data_i = 4'h0;
        tick(); tick();
        chk("rst_oe", 64'(data_oe), 64'h0);
        chk("rst_dout", 64'(data_o), 64'h0);
        chk("rst_port", port_out, 64'h0);
        chk("rst_phase", 64'(dut.r_phase), 64'(PH_IDLE));
        reset = 1'b1;
        tick(); tick(); tick();
        chk("idle_wait_phase", 64'(dut.r_phase), 64'(PH_IDLE));
        sync = 1'b1;
        tick();
        sync = 1'b0;
        any_bad = 1'b0;
        for (int k = 1; k < 6; k++) begin
            if (data_oe || data_oe2 || (port_out != 64'h0) || (port_out2 != 32'h0)) any_bad = 1'b1;
            tick();
        end
        chk("first_x1_phase", 64'(dut.r_phase), 64'(PH_X1));
        tick();
        chk("first_x2_phase", 64'(dut.r_phase), 64'(PH_X2));
        chk("first_quiet", 64'(any_bad), 64'h0);
        tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;

        // Table-driven bus cycles
        foreach (tbl[i]) begin
            run_bus(tbl[i].cm_m2, tbl[i].cm_x2, tbl[i].d_m2, tbl[i].d_x2, tbl[i].d_x3, o1, o2, r1, r2);
            chk({tbl[i].name, "_oe"}, 64'(o1), 64'(tbl[i].oe1));
            if (tbl[i].oe1[6]) chk({tbl[i].name, "_dout"}, 64'(r1), 64'(tbl[i].do1));
            chk({tbl[i].name, "_port"}, port_out, tbl[i].pt1);
            chk({tbl[i].name, "_oe_c2"}, 64'(o2), 64'(tbl[i].oe2));
            if (tbl[i].oe2[6]) chk({tbl[i].name, "_dout_c2"}, 64'(r2), 64'(tbl[i].do2));
            chk({tbl[i].name, "_port_c2"}, 64'(port_out2), 64'(tbl[i].pt2));
        end

        // sync during X2 of a WRM: the write must be dropped
        rdm_prefix(4);
        sync = 1'b0; cmd_n = 4'hD; data_i = 4'h0; tick();   // M2 with WRM opcode
        cmd_n = 4'hF; tick();                               // X1
        sync = 1'b1; data_i = 4'hF; tick();                 // X2 aborted by sync
        sync = 1'b0; data_i = 4'h0;
        chk("abort_phase", 64'(dut.r_phase), 64'(PH_A1));
        run_bus(4'hD, 4'hF, 4'h9, 4'h0, 4'h0, o1, o2, r1, r2);
        chk("abort_oe", 64'(o1), 64'(OE_X2));
        chk("abort_no_write", 64'(r1), 64'h5);

        // sync during X1 of an RDM: no drive, pending op cleared
        rdm_prefix(5);
        sync = 1'b1; tick();
        sync = 1'b0;
        chk("sync_x1_oe", 64'({data_oe, data_oe2}), 64'h0);
        run_bus(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, o1, o2, r1, r2);
        chk("sync_x1_pend_cleared", 64'({o1, o2}), 64'h0);

        // Reset during X1 of an RDM
        rdm_prefix(5);
        reset = 1'b0; tick();
        reset = 1'b1;
        chk("rst_x1_oe", 64'({data_oe, data_oe2}), 64'h0);
        chk("rst_x1_dout", 64'(data_o), 64'h0);
        chk("rst_x1_port", port_out, 64'h0);
        chk("rst_x1_port_c2", 64'(port_out2), 64'h0);
        chk("rst_x1_phase", 64'(dut.r_phase), 64'(PH_IDLE));
        any_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (data_oe || data_oe2) any_bad = 1'b1;
        end
        chk("rst_hold_oe", 64'(any_bad), 64'h0);
        chk("rst_hold_phase", 64'(dut.r_phase), 64'(PH_IDLE));
        sync = 1'b1; tick();
        sync = 1'b0;
        chk("resync_phase", 64'(dut.r_phase), 64'(PH_A1));

        // Free-run: X3 without sync wraps to A1
        for (int k = 0; k < 7; k++) tick();
        chk("freerun_x3", 64'(dut.r_phase), 64'(PH_X3));
        tick();
        chk("freerun_a1", 64'(dut.r_phase), 64'(PH_A1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
